pe_act_scheduler: RTL

- Pop-side sequencer for the PE activation queue.
- Pulls one activation/index pair from the queue head and replays it to the MAC datapath once per output row assigned to this PE, using a valid/ready handshake.
- Detects the end-of-layer marker, signals layer completion and keeps a per-layer count of issued activations.
- Sits between the activation queue (network-interface side) and the PE MAC/weight-fetch datapath.

---
 rtl/pe_act_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pe_act_scheduler.sv
// Pop-side sequencer for the PE activation queue: replays each popped activation
// once per assigned row to the MAC datapath. Optional macro: PE_ACT_ZERO_SKIP_EN.
module pe_act_scheduler #(
   parameter int QUEUE_WIDTH = 32,
   parameter int ACT_WIDTH   = 16,
   parameter int IDX_WIDTH   = 16,
   parameter int ROW_WIDTH   = 6,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [ROW_WIDTH-1:0]   cfg_num_rows,
   input  logic                   queue_empty,
   input  logic [QUEUE_WIDTH-1:0] act_out,
   output logic                   pop_act,
   output logic                   dp_valid,
   input  logic                   dp_ready,
   output logic [ACT_WIDTH-1:0]   dp_act,
   output logic [IDX_WIDTH-1:0]   dp_idx,
   output logic [ROW_WIDTH-1:0]   dp_row,
   output logic                   dp_last,
   output logic                   layer_done,
   output logic                   busy,
   output logic [CNT_WIDTH-1:0]   act_cnt
);

   // Handshake: a request transfers on a cycle with dp_valid=1 and dp_ready=1;
   // while dp_valid=1 and dp_ready=0 the payload (act/idx/row/last) is held.

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   localparam logic [ROW_WIDTH-1:0] ROW_ONE = ROW_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t                 state, state_nxt, load_target;
   logic [ACT_WIDTH-1:0]   act_q;
   logic [IDX_WIDTH-1:0]   idx_q;
   logic [ROW_WIDTH-1:0]   rows_q;
   logic [ROW_WIDTH-1:0]   row_q;
   logic [ACT_WIDTH-1:0]   head_act;
   logic [IDX_WIDTH-1:0]   head_idx;
   logic                   head_marker;
   logic                   head_skip;
   logic                   last_hs;
   logic                   load;

   always_comb begin
      head_act    = act_out[QUEUE_WIDTH-1 -: ACT_WIDTH];
      head_idx    = act_out[IDX_WIDTH-1:0];
      head_marker = &head_idx;
`ifdef PE_ACT_ZERO_SKIP_EN
      head_skip   = (cfg_num_rows == '0) || (head_act == '0);
`else
      head_skip   = (cfg_num_rows == '0);
`endif
      // The marker takes precedence over the discard rules.
      if (head_marker)
         load_target = DONE;
      else if (head_skip)
         load_target = IDLE;
      else
         load_target = ISSUE;
   end

   always_comb begin
      dp_valid   = (state == ISSUE);
      dp_last    = (state == ISSUE) && (row_q == rows_q - ROW_ONE);
      layer_done = (state == DONE);
      busy       = (state != IDLE);
      last_hs    = dp_valid && dp_ready && dp_last;
      // rst is folded in so the strobe is low for the whole reset assertion.
      load       = !rst && enable && !queue_empty && ((state == IDLE) || last_hs);
      pop_act    = load;
      dp_act     = act_q;
      dp_idx     = idx_q;
      dp_row     = row_q;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = load_target;
         ISSUE:   if (last_hs) state_nxt = load ? load_target : IDLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_q   <= '0;
         idx_q   <= '0;
         rows_q  <= '0;
         row_q   <= '0;
         act_cnt <= '0;
      end else begin
         if (load) begin
            act_q  <= head_act;
            idx_q  <= head_idx;
            rows_q <= cfg_num_rows;
            row_q  <= '0;
         end else if (dp_valid && dp_ready && !dp_last) begin
            row_q <= row_q + ROW_ONE;
         end

         if (state == DONE)
            act_cnt <= '0;
         else if (last_hs && (act_cnt != '1))
            act_cnt <= act_cnt + CNT_ONE;
      end
   end

endmodule
